// File: rtl/eq_pkg.sv
// Shared types and constants for the EQ coefficient fetch path.
package eq_pkg;

    localparam int NUM_BANDS     = 2;
    localparam int NUM_TAPS      = 10;
    localparam int FILT_PER_BAND = 16;
    localparam int GAIN_W        = $clog2(FILT_PER_BAND);
    localparam int COEFF_W       = 16;
    localparam int ADDR_W        = 11;
    localparam int ROM_LAT       = 1;

    // Address arithmetic is done wider than the ROM address, then truncated.
    localparam int AW_EXT = ADDR_W + 4;

    localparam logic [7:0] LAST_TAP  = 8'(NUM_TAPS - 1);
    localparam logic [3:0] LAST_BAND = 4'(NUM_BANDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [COEFF_W-1:0] data;
        logic [7:0]         tap;
        logic [3:0]         band;
        logic               last;
    } coeff_beat_t;

    // ROM word address of (band, gain variant, tap).
    function automatic logic [ADDR_W-1:0] coeff_addr(input logic [3:0]        band,
                                                     input logic [GAIN_W-1:0] gain,
                                                     input logic [7:0]        tap);
        logic [AW_EXT-1:0] a;
        a = (AW_EXT'(band) * AW_EXT'(FILT_PER_BAND) + AW_EXT'(gain)) * AW_EXT'(NUM_TAPS)
            + AW_EXT'(tap);
        return a[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/coeff_skid_fifo.sv
// Two-entry FIFO of coefficient beats sitting behind the ROM output stage.
// Push and pop in the same cycle are allowed at any fill level, including full.
module coeff_skid_fifo
    import eq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  coeff_beat_t push_beat,
    input  logic        pop,
    output coeff_beat_t head,
    output logic [1:0]  count
);

    coeff_beat_t mem [2];
    logic        wr_ptr;
    logic        rd_ptr;

    // Storage: no reset needed, count qualifies the contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_beat;
        end
    end

    // Pointers and fill count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/coeff_fetch_sequencer.sv
// Walks the shared coefficient ROM once per sample strobe (band 0 taps 0..N-1,
// then band 1, ...) and streams the coefficients to the MAC.
//
// Handshake: a beat transfers on a cycle where coeff_valid and coeff_ready are
// both high; coeff_valid never drops and coeff_* never change until that cycle.
//
// Storage behind the ROM is the ROM output stage plus a 2-entry FIFO. When the
// FIFO is empty the ROM output stage drives the outputs directly, so the first
// coefficient appears two cycles after the strobe. An address is issued only
// while fewer than two beats are outstanding after this cycle's pop, which keeps
// 1 coeff/clk with ready high and guarantees nothing is lost under back-pressure.
module coeff_fetch_sequencer
    import eq_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        sample_strobe,
    input  logic [NUM_BANDS*GAIN_W-1:0] gain_sel,
    output logic                        busy,
    output logic                        overrun,
    output logic [ADDR_W-1:0]           rom_addr,
    input  logic [COEFF_W-1:0]          rom_data,
    output logic                        coeff_valid,
    input  logic                        coeff_ready,
    output logic [COEFF_W-1:0]          coeff_data,
    output logic [7:0]                  coeff_tap,
    output logic [3:0]                  coeff_band,
    output logic                        coeff_last,
    output logic                        frame_done,
    output fetch_state_e                dbg_state
);

    fetch_state_e state, state_next;

    logic [NUM_BANDS*GAIN_W-1:0] gain_shadow;
    logic [7:0]                  tap_cnt;
    logic [3:0]                  band_cnt;

    // Sideband aligned with rom_addr (req_*) and with rom_data (dat_*).
    logic       req_v, dat_v;
    logic [7:0] req_tap, dat_tap;
    logic [3:0] req_band, dat_band;
    logic       req_last, dat_last;

    logic [NUM_BANDS*GAIN_W-1:0] gain_src;
    logic [GAIN_W-1:0]           cur_gain;
    logic                        last_addr;
    logic [1:0]                  fifo_count;
    logic                        fifo_empty;
    coeff_beat_t                 fifo_head;
    coeff_beat_t                 dat_beat;
    coeff_beat_t                 head;
    logic                        out_v;
    logic                        pop;
    logic                        fifo_push;
    logic                        fifo_pop;
    logic [2:0]                  occupancy;
    logic [2:0]                  occ_after;
    logic                        credit_ok;
    logic                        issue;
    logic                        frame_done_next;
    logic                        overrun_next;

    // Datapath: gain lookup, output selection and issue credit.
    always_comb begin
        gain_src = (state == IDLE) ? gain_sel : gain_shadow;
        cur_gain = '0;
        for (int b = 0; b < NUM_BANDS; b++) begin
            if (band_cnt == 4'(b)) begin
                cur_gain = gain_src[b*GAIN_W +: GAIN_W];
            end
        end
        last_addr = (band_cnt == LAST_BAND) && (tap_cnt == LAST_TAP);

        dat_beat.data = rom_data;
        dat_beat.tap  = dat_tap;
        dat_beat.band = dat_band;
        dat_beat.last = dat_last;

        fifo_empty = (fifo_count == 2'd0);
        out_v      = !fifo_empty || dat_v;
        head       = fifo_empty ? dat_beat : fifo_head;
        pop        = out_v && coeff_ready;
        fifo_pop   = pop && !fifo_empty;
        // ROM output goes to the FIFO unless it leaves directly this cycle.
        fifo_push  = dat_v && !(fifo_empty && coeff_ready);

        occupancy = 3'(req_v) + 3'(dat_v) + 3'(fifo_count);
        occ_after = occupancy - 3'(pop);
        credit_ok = (occ_after < 3'd2);
    end

    // FSM next state, issue decision and pulse outputs.
    always_comb begin
        state_next      = state;
        issue           = 1'b0;
        frame_done_next = 1'b0;
        overrun_next    = 1'b0;
        case (state)
            IDLE: begin
                if (sample_strobe) begin
                    issue      = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                overrun_next = sample_strobe;
                if (credit_ok) begin
                    issue = 1'b1;
                    if (last_addr) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                overrun_next = sample_strobe;
                if (occ_after == 3'd0) begin
                    state_next      = IDLE;
                    frame_done_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and registered pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_next;
            frame_done <= frame_done_next;
            overrun    <= overrun_next;
        end
    end

    // Gain snapshot: tracks the input while idle, frozen during a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            gain_shadow <= '0;
        end else if (state == IDLE) begin
            gain_shadow <= gain_sel;
        end
    end

    // Tap/band walk, registered ROM address and the sideband pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            tap_cnt  <= '0;
            band_cnt <= '0;
            rom_addr <= '0;
            req_v    <= 1'b0;
            req_tap  <= '0;
            req_band <= '0;
            req_last <= 1'b0;
            dat_v    <= 1'b0;
            dat_tap  <= '0;
            dat_band <= '0;
            dat_last <= 1'b0;
        end else begin
            req_v <= issue;
            if (issue) begin
                rom_addr <= coeff_addr(band_cnt, cur_gain, tap_cnt);
                req_tap  <= tap_cnt;
                req_band <= band_cnt;
                req_last <= (tap_cnt == LAST_TAP);
                if (tap_cnt == LAST_TAP) begin
                    tap_cnt  <= '0;
                    band_cnt <= (band_cnt == LAST_BAND) ? 4'd0 : band_cnt + 4'd1;
                end else begin
                    tap_cnt <= tap_cnt + 8'd1;
                end
            end
            dat_v    <= req_v;
            dat_tap  <= req_tap;
            dat_band <= req_band;
            dat_last <= req_last;
        end
    end

    coeff_skid_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_beat (dat_beat),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign busy        = (state != IDLE);
    assign coeff_valid = out_v;
    assign coeff_data  = head.data;
    assign coeff_tap   = head.tap;
    assign coeff_band  = head.band;
    assign coeff_last  = head.last;
    assign dbg_state   = state;

endmodule
